// File: rtl/mil_bc_pkg.sv
// Shared types and constants for the MIL-STD-1553 bus-controller message sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mil_bc_pkg;

    // Message-level sequencer states
    typedef enum logic [2:0] {
        IDLE,
        TX_CW,
        TX_DW,
        WAIT_SW,
        RX_DW,
        DONE
    } bc_state_t;

    // Per-word transmit handshake phase inside TX_CW / TX_DW
    typedef enum logic [1:0] {
        PH_SEND,    // load dat, pulse txen, arm start timer
        PH_RISE,    // waiting for the transmitter to go busy
        PH_FALL     // word on the wire, waiting for it to finish
    } tx_ph_t;

    // Result codes reported on err
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_TO   = 2'd1;
    localparam logic [1:0] ERR_SYNC = 2'd2;
    localparam logic [1:0] ERR_ADDR = 2'd3;

    // Default timing: 14 us response window and transmitter start limit at 50 MHz
    localparam int TO_CYC_DEF  = 700;
    localparam int TXS_CYC_DEF = 8;

    // Command-word field positions
    localparam int CW_RT_HI = 15;
    localparam int CW_RT_LO = 11;
    localparam int CW_TR    = 10;
    localparam int CW_SA_HI = 9;
    localparam int CW_SA_LO = 5;
    localparam int CW_WC_HI = 4;
    localparam int CW_WC_LO = 0;

    // Data words carried by a command: word count 0 means 32, mode codes carry none
    function automatic logic [5:0] n_words(input logic [15:0] cw);
        logic [4:0] sa;
        logic [4:0] wc;
        sa = cw[CW_SA_HI:CW_SA_LO];
        wc = cw[CW_WC_HI:CW_WC_LO];
        if (sa == 5'd0 || sa == 5'd31) begin
            return 6'd0;
        end else if (wc == 5'd0) begin
            return 6'd32;
        end else begin
            return {1'b0, wc};
        end
    endfunction

endpackage

// File: rtl/mil_bc_seq_if.sv
// Bus bundle between the BC sequencer and its host / MIL_TXD / MIL_RXD / buffers.
// Latency: n/a (wires only).
// Backpressure: transmit paced by en_tx, receive by ok_rx strobes; no ready signals.
interface mil_bc_seq_if;
    logic        st;
    logic [15:0] cw;
    logic [15:0] dw_dat;
    logic        en_tx;
    logic        ok_rx;
    logic [15:0] sr_dat;
    logic        CW_DW;
    logic        txen;
    logic [15:0] dat;
    logic [4:0]  dw_adr;
    logic        rx_we;
    logic [4:0]  rx_adr;
    logic [15:0] rx_dat;
    logic [15:0] sw_rx;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    // master: the sequencer itself, which drives the message outputs
    modport master (
        input  st, cw, dw_dat, en_tx, ok_rx, sr_dat, CW_DW,
        output txen, dat, dw_adr, rx_we, rx_adr, rx_dat, sw_rx, busy, done, err
    );

    // slave: host, transceiver and buffer side
    modport slave (
        output st, cw, dw_dat, en_tx, ok_rx, sr_dat, CW_DW,
        input  txen, dat, dw_adr, rx_we, rx_adr, rx_dat, sw_rx, busy, done, err
    );
endinterface

// File: rtl/mil_bc_timer.sv
// Loadable down-counter: restart loads i_val, o_exp pulses i_val cycles after the restart edge.
// Latency: o_exp is combinational from the count, asserted in the i_val-th cycle after restart.
// Backpressure: none; restart wins over clear and expiry, timer idles after expiring.
module mil_bc_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_restart,
    input  logic         i_clr,
    input  logic [W-1:0] i_val,
    output logic         o_exp
);
    logic [W-1:0] r_cnt;
    logic         r_run;

    assign o_exp = r_run && (r_cnt == W'(1));

    // Count down while armed; stop on clear or after the expiry cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_restart) begin
            r_cnt <= i_val;
            r_run <= 1'b1;
        end else if (i_clr || o_exp) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (r_run) begin
            r_cnt <= r_cnt - W'(1);
        end
    end
endmodule

// File: rtl/mil_bc_seq.sv
// BC message sequencer: sends CW (+ DWs), takes RT status (+ DWs), reports err and a done pulse.
// Latency: busy one cycle after st; TXS_CYC transmitter-start limit, TO_CYC response timeout.
// Backpressure: none; words paced by en_tx / ok_rx, st ignored until the message completes.
module mil_bc_seq
    import mil_bc_pkg::*;
#(
    parameter int TO_CYC  = TO_CYC_DEF,
    parameter int TXS_CYC = TXS_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mil_bc_seq_if.master bus
);
    localparam int TMR_MAX = (TO_CYC > TXS_CYC) ? TO_CYC : TXS_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_TO  = TMR_W'(TO_CYC);
    localparam logic [TMR_W-1:0] TMR_TXS = TMR_W'(TXS_CYC);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    bc_state_t        r_state, w_state;
    tx_ph_t           r_ph, w_ph;
    logic [15:0]      r_cw, w_cw;
    logic [5:0]       r_n, w_n;
    logic [5:0]       r_idx, w_idx, w_idx_inc;
    logic             r_txen, w_txen;
    logic [15:0]      r_dat, w_dat;
    logic [4:0]       r_dw_adr, w_dw_adr;
    logic             r_rx_we, w_rx_we;
    logic [4:0]       r_rx_adr, w_rx_adr;
    logic [15:0]      r_rx_dat, w_rx_dat;
    logic [15:0]      r_sw_rx, w_sw_rx;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic [1:0]       r_err, w_err;
    logic             w_fin;
    logic             w_tr;
    logic             w_rt_ok;
    logic             w_tmr_restart, w_tmr_clr, w_tmr_exp;
    logic [TMR_W-1:0] w_tmr_val;

    // Reset asserts at once and releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_tr      = r_cw[CW_TR];
    assign w_rt_ok   = (bus.sr_dat[CW_RT_HI:CW_RT_LO] == r_cw[CW_RT_HI:CW_RT_LO]);
    assign w_idx_inc = r_idx + 6'd1;

    // One timer serves both the transmitter-start window and the RT response window
    mil_bc_timer #(.W(TMR_W)) u_tmr (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .i_restart (w_tmr_restart),
        .i_clr     (w_tmr_clr),
        .i_val     (w_tmr_val),
        .o_exp     (w_tmr_exp)
    );

    // Next-state and next-output decode for the whole message
    always_comb begin
        w_state       = r_state;
        w_ph          = r_ph;
        w_cw          = r_cw;
        w_n           = r_n;
        w_idx         = r_idx;
        w_txen        = 1'b0;
        w_dat         = r_dat;
        w_dw_adr      = r_dw_adr;
        w_rx_we       = 1'b0;
        w_rx_adr      = r_rx_adr;
        w_rx_dat      = r_rx_dat;
        w_sw_rx       = r_sw_rx;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_err         = r_err;
        w_fin         = 1'b0;
        w_tmr_restart = 1'b0;
        w_tmr_clr     = 1'b0;
        w_tmr_val     = TMR_TO;

        case (r_state)
            IDLE: begin
                if (bus.st) begin
                    w_cw    = bus.cw;
                    w_n     = n_words(bus.cw);
                    w_busy  = 1'b1;
                    w_err   = ERR_OK;
                    w_ph    = PH_SEND;
                    w_state = TX_CW;
                end
            end

            TX_CW, TX_DW: begin
                case (r_ph)
                    PH_SEND: begin
                        // dw_adr has been stable for a cycle, so dw_dat is already valid
                        w_txen        = 1'b1;
                        w_dat         = (r_state == TX_CW) ? r_cw : bus.dw_dat;
                        w_tmr_restart = 1'b1;
                        w_tmr_val     = TMR_TXS;
                        w_ph          = PH_RISE;
                    end
                    PH_RISE: begin
                        if (bus.en_tx) begin
                            w_tmr_clr = 1'b1;
                            w_ph      = PH_FALL;
                        end else if (w_tmr_exp) begin
                            w_err = ERR_TO;
                            w_fin = 1'b1;
                        end
                    end
                    default: begin
                        if (!bus.en_tx) begin
                            if (r_state == TX_CW && !w_tr && r_n != 6'd0) begin
                                w_state  = TX_DW;
                                w_idx    = 6'd0;
                                w_dw_adr = 5'd0;
                                w_ph     = PH_SEND;
                            end else if (r_state == TX_DW && w_idx_inc != r_n) begin
                                w_idx    = w_idx_inc;
                                w_dw_adr = w_idx_inc[4:0];
                                w_ph     = PH_SEND;
                            end else begin
                                // Response window opens on the end of the last word sent
                                w_state       = WAIT_SW;
                                w_tmr_restart = 1'b1;
                            end
                        end
                    end
                endcase
            end

            WAIT_SW: begin
                if (bus.ok_rx) begin
                    if (!bus.CW_DW) begin
                        w_err = ERR_SYNC;
                        w_fin = 1'b1;
                    end else if (!w_rt_ok) begin
                        w_err = ERR_ADDR;
                        w_fin = 1'b1;
                    end else begin
                        w_sw_rx = bus.sr_dat;
                        if (w_tr && r_n != 6'd0) begin
                            w_state       = RX_DW;
                            w_idx         = 6'd0;
                            w_tmr_restart = 1'b1;
                        end else begin
                            w_fin = 1'b1;
                        end
                    end
                end else if (w_tmr_exp) begin
                    w_err = ERR_TO;
                    w_fin = 1'b1;
                end
            end

            RX_DW: begin
                if (bus.ok_rx) begin
                    if (bus.CW_DW) begin
                        w_err = ERR_SYNC;
                        w_fin = 1'b1;
                    end else begin
                        w_rx_we  = 1'b1;
                        w_rx_adr = r_idx[4:0];
                        w_rx_dat = bus.sr_dat;
                        w_idx    = w_idx_inc;
                        if (w_idx_inc == r_n) begin
                            w_fin = 1'b1;
                        end else begin
                            w_tmr_restart = 1'b1;
                        end
                    end
                end else if (w_tmr_exp) begin
                    w_err = ERR_TO;
                    w_fin = 1'b1;
                end
            end

            DONE: begin
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        // Completion: done pulses for the single DONE cycle, busy drops with it
        if (w_fin) begin
            w_state   = DONE;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_tmr_clr = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= IDLE;
            r_ph     <= PH_SEND;
            r_cw     <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_txen   <= 1'b0;
            r_dat    <= '0;
            r_dw_adr <= '0;
            r_rx_we  <= 1'b0;
            r_rx_adr <= '0;
            r_rx_dat <= '0;
            r_sw_rx  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= ERR_OK;
        end else begin
            r_state  <= w_state;
            r_ph     <= w_ph;
            r_cw     <= w_cw;
            r_n      <= w_n;
            r_idx    <= w_idx;
            r_txen   <= w_txen;
            r_dat    <= w_dat;
            r_dw_adr <= w_dw_adr;
            r_rx_we  <= w_rx_we;
            r_rx_adr <= w_rx_adr;
            r_rx_dat <= w_rx_dat;
            r_sw_rx  <= w_sw_rx;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    assign bus.txen   = r_txen;
    assign bus.dat    = r_dat;
    assign bus.dw_adr = r_dw_adr;
    assign bus.rx_we  = r_rx_we;
    assign bus.rx_adr = r_rx_adr;
    assign bus.rx_dat = r_rx_dat;
    assign bus.sw_rx  = r_sw_rx;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_mil_bc_seq.sv
// Directed bench for mil_bc_seq: transmitter model, hand-driven RT replies, hand-computed results.
// Latency: n/a.
// Backpressure: n/a.
module tb_mil_bc_seq;
    logic clk;
    logic rst_n;
    logic txd_en;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    // Transmitter / monitor bookkeeping
    int          tx_cnt = 0;
    int          fall_cnt = 0;
    int          done_cnt = 0;
    int          fall_cyc = 0;
    int          txen_cyc = 0;
    int          done_cyc = 0;
    logic        done_busy = 1'b0;
    logic [4:0]  adr_q = '0;
    logic [15:0] tx_dat_q [$];
    logic [4:0]  tx_adr_q [$];
    logic [4:0]  rx_adr_q [$];
    logic [15:0] rx_dat_q [$];
    logic [15:0] dw_mem [32];

    mil_bc_seq_if bus ();

    mil_bc_seq #(.TO_CYC(700), .TXS_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.dw_dat = dw_mem[bus.dw_adr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        tx_cnt   = 0;
        fall_cnt = 0;
        done_cnt = 0;
        tx_dat_q.delete();
        tx_adr_q.delete();
        rx_adr_q.delete();
        rx_dat_q.delete();
    endtask

    task automatic start(input logic [15:0] c);
        bus.cw = c;
        bus.st = 1'b1;
        tick(1);
        bus.st = 1'b0;
    endtask

    task automatic rt_word(input logic [15:0] w, input logic sync);
        bus.sr_dat = w;
        bus.CW_DW  = sync;
        bus.ok_rx  = 1'b1;
        tick(1);
        bus.ok_rx  = 1'b0;
    endtask

    task automatic wait_falls(input int n, input int max, input string tag);
        for (int i = 0; i < max && fall_cnt < n; i++) tick(1);
        check(tag, 32'(fall_cnt), 32'(n));
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max && done_cnt < 1; i++) tick(1);
        check(tag, 32'(done_cnt), 32'd1);
        tick(2);
    endtask

    // Output monitor: txen words (with the dw_adr of the cycle before), rx writes, done pulses
    always @(negedge clk) begin
        if (bus.txen) begin
            tx_cnt++;
            tx_dat_q.push_back(bus.dat);
            tx_adr_q.push_back(adr_q);
            txen_cyc = cyc;
        end
        adr_q = bus.dw_adr;
        if (bus.rx_we) begin
            rx_adr_q.push_back(bus.rx_adr);
            rx_dat_q.push_back(bus.rx_dat);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
    end

    // MIL_TXD model: busy 2 cycles after txen, word lasts 4 cycles.
    // fall_cyc is the cycle count at the first edge that samples en_tx low.
    initial begin
        bus.en_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (txd_en && bus.txen) begin
                tick(2);
                bus.en_tx = 1'b1;
                tick(4);
                bus.en_tx = 1'b0;
                fall_cnt++;
                fall_cyc = cyc + 1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        txd_en     = 1'b1;
        bus.st     = 1'b0;
        bus.cw     = '0;
        bus.ok_rx  = 1'b0;
        bus.sr_dat = '0;
        bus.CW_DW  = 1'b0;
        for (int i = 0; i < 32; i++) dw_mem[i] = 16'hA000 + 16'(i);
        #2 rst_n = 1'b0;
        tick(3);

        // Reset state
        check("rst_txen",   32'(bus.txen),   32'd0);
        check("rst_rx_we",  32'(bus.rx_we),  32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_err",    32'(bus.err),    32'd0);
        check("rst_dat",    32'(bus.dat),    32'd0);
        check("rst_sw_rx",  32'(bus.sw_rx),  32'd0);
        check("rst_rx_dat", 32'(bus.rx_dat), 32'd0);
        check("rst_dw_adr", 32'(bus.dw_adr), 32'd0);
        check("rst_rx_adr", 32'(bus.rx_adr), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Receive message: RT1 R SA1 N=3
        clr_logs();
        start(16'h0823);
        check("t1_busy", 32'(bus.busy), 32'd1);
        wait_falls(4, 200, "t1_falls");
        tick(3);
        rt_word(16'h0800, 1'b1);
        wait_done(50, "t1_done");
        check("t1_txen_cnt", 32'(tx_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_dat%0d", i),
                  (i < tx_dat_q.size()) ? 32'(tx_dat_q[i]) : 32'hDEAD_BEEF,
                  (i == 0) ? 32'h0823 : 32'hA000 + 32'(i - 1));
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t1_dw_adr%0d", i - 1),
                  (i < tx_adr_q.size()) ? 32'(tx_adr_q[i]) : 32'hDEAD_BEEF, 32'(i - 1));
        end
        check("t1_sw_rx",     32'(bus.sw_rx), 32'h0800);
        check("t1_err",       32'(bus.err),   32'd0);
        check("t1_done_busy", 32'(done_busy), 32'd0);
        check("t1_busy_end",  32'(bus.busy),  32'd0);
        check("t1_no_rx",     32'(rx_adr_q.size()), 32'd0);

        // Transmit message: RT1 T SA1 N=2
        clr_logs();
        start(16'h0C22);
        wait_falls(1, 100, "t2_falls");
        tick(3);
        rt_word(16'h0800, 1'b1);
        tick(2);
        rt_word(16'h1234, 1'b0);
        tick(2);
        rt_word(16'h5678, 1'b0);
        wait_done(20, "t2_done");
        check("t2_txen_cnt", 32'(tx_cnt), 32'd1);
        check("t2_rx_cnt",   32'(rx_adr_q.size()), 32'd2);
        check("t2_rx_adr0", (rx_adr_q.size() > 0) ? 32'(rx_adr_q[0]) : 32'hDEAD_BEEF, 32'd0);
        check("t2_rx_dat0", (rx_dat_q.size() > 0) ? 32'(rx_dat_q[0]) : 32'hDEAD_BEEF, 32'h1234);
        check("t2_rx_adr1", (rx_adr_q.size() > 1) ? 32'(rx_adr_q[1]) : 32'hDEAD_BEEF, 32'd1);
        check("t2_rx_dat1", (rx_dat_q.size() > 1) ? 32'(rx_dat_q[1]) : 32'hDEAD_BEEF, 32'h5678);
        check("t2_sw_rx",    32'(bus.sw_rx), 32'h0800);
        check("t2_err",      32'(bus.err),   32'd0);

        // No response: 1 CW + 1 DW, done exactly 700 cycles after the last word ends
        clr_logs();
        start(16'h0821);
        wait_falls(2, 200, "t3_falls");
        wait_done(800, "t3_done");
        check("t3_txen_cnt", 32'(tx_cnt), 32'd2);
        check("t3_err",      32'(bus.err), 32'd1);
        check("t3_to_cycles", 32'(done_cyc - fall_cyc), 32'd700);

        // Wrong RT address in status: sw_rx keeps the previous status
        clr_logs();
        start(16'h0C22);
        wait_falls(1, 100, "t4_falls");
        tick(3);
        rt_word(16'h1000, 1'b1);
        wait_done(20, "t4_done");
        check("t4_err",    32'(bus.err),   32'd3);
        check("t4_sw_rx",  32'(bus.sw_rx), 32'h0800);
        check("t4_no_rx",  32'(rx_adr_q.size()), 32'd0);

        // Status arriving with data sync
        clr_logs();
        start(16'h0C22);
        wait_falls(1, 100, "t5_falls");
        tick(3);
        rt_word(16'h0800, 1'b0);
        wait_done(20, "t5_done");
        check("t5_err", 32'(bus.err), 32'd2);

        // Mode code SA0: only the CW, status accepted, nothing written
        clr_logs();
        start(16'h0C02);
        wait_falls(1, 100, "t6_falls");
        tick(3);
        rt_word(16'h0801, 1'b1);
        wait_done(20, "t6_done");
        tick(5);
        check("t6_txen_cnt", 32'(tx_cnt), 32'd1);
        check("t6_sw_rx",    32'(bus.sw_rx), 32'h0801);
        check("t6_err",      32'(bus.err), 32'd0);
        check("t6_no_rx",    32'(rx_adr_q.size()), 32'd0);

        // Transmitter never goes busy: start timeout after 8 cycles
        clr_logs();
        txd_en = 1'b0;
        start(16'h0C22);
        wait_done(40, "t7_done");
        check("t7_err",      32'(bus.err), 32'd1);
        check("t7_txen_cnt", 32'(tx_cnt), 32'd1);
        check("t7_txs_cycles", 32'(done_cyc - txen_cyc), 32'd8);
        txd_en = 1'b1;

        // Reset during DW1, then a clean message
        clr_logs();
        start(16'h0823);
        for (int i = 0; i < 200 && tx_cnt < 3; i++) tick(1);
        check("t8_reach_dw1", 32'(tx_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_busy",   32'(bus.busy),   32'd0);
        check("t8_rst_dat",    32'(bus.dat),    32'd0);
        check("t8_rst_dw_adr", 32'(bus.dw_adr), 32'd0);
        check("t8_rst_txen",   32'(bus.txen),   32'd0);
        check("t8_rst_sw_rx",  32'(bus.sw_rx),  32'd0);
        tick(12);
        check("t8_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        tick(4);
        clr_logs();
        start(16'h0821);
        wait_falls(2, 200, "t8_falls");
        tick(3);
        rt_word(16'h0800, 1'b1);
        wait_done(20, "t8_done");
        check("t8_txen_cnt", 32'(tx_cnt), 32'd2);
        check("t8_dat1", (tx_dat_q.size() > 1) ? 32'(tx_dat_q[1]) : 32'hDEAD_BEEF, 32'hA000);
        check("t8_err",      32'(bus.err), 32'd0);
        check("t8_sw_rx",    32'(bus.sw_rx), 32'h0800);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mil_bc_seq.md
MIL_BC_SEQ -- requirements
Module: mil_bc_seq

Interface
REQ-001 Parameter TO_CYC, default 700: response timeout in clk cycles, 14 us at 50 MHz.
REQ-002 Parameter TXS_CYC, default 8: maximum cycles from txen pulse to en_tx rising.
REQ-003 clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 st  in  1  one-cycle start-message request.
REQ-006 cw  in  16  command word: [15:11] RT addr, [10] T/R (1 = RT transmits), [9:5] subaddr, [4:0] word count.
REQ-007 dw_dat  in  16  BC-to-RT data word at address dw_adr.
REQ-008 en_tx  in  1  transmitter busy flag from MIL_TXD.
REQ-009 ok_rx  in  1  one-cycle strobe from MIL_RXD: a valid word is on sr_dat.
REQ-010 sr_dat  in  16  received word.
REQ-011 CW_DW  in  1  received sync type: 1 = command/status sync, 0 = data sync.
REQ-012 txen  out  1  one-cycle pulse starting transmission of dat.
REQ-013 dat  out  16  word to MIL_TXD; held stable from txen until en_tx falls.
REQ-014 dw_adr  out  5  index of the BC-to-RT data word requested.
REQ-015 rx_we, rx_adr[4:0], rx_dat[15:0]  out  received-data-word write port.
REQ-016 sw_rx  out  16  last received status word.
REQ-017 busy  out  1  message in progress; done  out  1  one-cycle completion pulse; err  out  2  result code (0 ok, 1 timeout, 2 wrong sync, 3 address mismatch).

Function
REQ-018 N = cw[4:0], with 0 meaning 32; subaddr 0 or 31 (mode code) forces N = 0.
REQ-019 States: IDLE, TX_CW, TX_DW, WAIT_SW, RX_DW, DONE.
REQ-020 IDLE: st latches cw; busy rises the next cycle; err clears; go to TX_CW; st is ignored while busy.
REQ-021 Word transmit handshake: dat loaded and txen asserted for one cycle; en_tx must rise within TXS_CYC cycles; the word ends on the en_tx falling edge.
REQ-022 If en_tx does not rise within TXS_CYC cycles: err = 1, go to DONE.
REQ-023 TX_CW with T/R = 0 and N > 0: go to TX_DW. Otherwise go to WAIT_SW.
REQ-024 TX_DW: sends words dw_adr = 0..N-1 back to back; dw_adr is valid one cycle before its txen; after the final word, go to WAIT_SW.
REQ-025 WAIT_SW timeout counter: starts at the en_tx fall; counts to TO_CYC, at which point err = 1 and the block goes to DONE.
REQ-026 WAIT_SW on ok_rx: CW_DW = 0 gives err = 2; sr_dat[15:11] != cw[15:11] gives err = 3. Otherwise sw_rx = sr_dat, then go to RX_DW if T/R = 1 and N > 0, else DONE.
REQ-027 RX_DW: each ok_rx with CW_DW = 0 gives rx_we = 1 for one cycle, rx_adr = index, rx_dat = sr_dat.
REQ-028 RX_DW: each word restarts the TO_CYC timer; CW_DW = 1 gives err = 2; timer expiry gives err = 1; after N words, go to DONE.
REQ-029 DONE: done pulses for one cycle, busy falls in the same cycle, return to IDLE.
REQ-030 ok_rx and timer expiry in the same cycle: ok_rx wins.
REQ-031 A received word index above 31 cannot occur; the counter is 6 bits and compares against N.

Reset
REQ-032 rst_n low: state IDLE; txen, rx_we, done, busy = 0; err = 0; dat, sw_rx, rx_dat, dw_adr, rx_adr = 0; timers = 0.
REQ-033 Reset asserted mid-message aborts immediately with no done pulse.
REQ-034 Reset release is synchronised: two-stage deassert synchroniser.

Structure
REQ-035 Package mil_bc_pkg holds: the state enum, the err code constants, the TO_CYC and TXS_CYC defaults, and the cw field bit positions.
REQ-036 Sub-module mil_bc_timer: loadable down-counter with restart input and expire pulse; used for both TXS_CYC and TO_CYC.

Verification
REQ-037 Receive message: cw = 0x0823 (RT1, R, SA1, N = 3), RT replies 0x0800 -> 4 txen pulses (dw_adr 0, 1, 2), sw_rx = 0x0800, err = 0, one done pulse.
REQ-038 Transmit message: cw = 0x0C22 (RT1, T, N = 2), RT replies 0x0800, 0x1234, 0x5678 -> rx_we twice at rx_adr 0/1 with those values, err = 0.
REQ-039 No response: cw = 0x0821 -> after 1 CW + 1 DW, done exactly TO_CYC = 700 cycles after the last en_tx fall, err = 1.
REQ-040 Wrong RT address: status 0x1000 for cw RT1 -> err = 3; data sync on the status word -> err = 2.
REQ-041 Mode code cw = 0x0C02 (SA0) -> only the CW is sent, status accepted, no rx_we.
REQ-042 rst_n pulled low during TX_DW word 1 -> all outputs 0 in the same cycle; a subsequent st runs a clean message.
